// File: rtl/sweep_scan_controller.sv
// Raster-sweep sequencer for the two-axis light tracker: steps theta/phi, waits for the servos to settle,
// samples the ADC at every grid point, tracks the peak and parks the servos there.
`timescale 1ns/1ps
module sweep_scan_controller #(
   parameter int THETA_STEPS   = 36,
   parameter int PHI_STEPS     = 9,
   parameter int SETTLE_CYCLES = 1000,
   parameter int ADC_W         = 12,
   parameter int ANG_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             adc_valid,
   input  logic [ADC_W-1:0] adc_data,
   output logic [ANG_W-1:0] theta_idx,
   output logic [ANG_W-1:0] phi_idx,
   output logic             sample_req,
   output logic             busy,
   output logic             done,
   output logic [ADC_W-1:0] max_volt,
   output logic [ANG_W-1:0] max_theta,
   output logic [ANG_W-1:0] max_phi
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SETTLE_CYCLES);
   localparam logic [ANG_W-1:0] THETA_LAST = ANG_W'(THETA_STEPS - 1);
   localparam logic [ANG_W-1:0] PHI_LAST   = ANG_W'(PHI_STEPS - 1);

   typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, WAIT_ADC, EVAL, PARK, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             first_q, first_d;
   logic [ADC_W-1:0] sample_q, sample_d;
   logic [ANG_W-1:0] theta_q, theta_d;
   logic [ANG_W-1:0] phi_q, phi_d;
   logic             sample_req_q, sample_req_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [ADC_W-1:0] max_volt_q, max_volt_d;
   logic [ANG_W-1:0] max_theta_q, max_theta_d;
   logic [ANG_W-1:0] max_phi_q, max_phi_d;

   logic             upd;
   logic [ADC_W-1:0] new_volt;
   logic [ANG_W-1:0] new_theta;
   logic [ANG_W-1:0] new_phi;

   always_comb begin
      // Strict compare keeps the earliest point on ties; the first sample always loads.
      upd       = first_q || (sample_q > max_volt_q);
      new_volt  = upd ? sample_q : max_volt_q;
      new_theta = upd ? theta_q  : max_theta_q;
      new_phi   = upd ? phi_q    : max_phi_q;

      state_d      = state_q;
      cnt_d        = cnt_q;
      first_d      = first_q;
      sample_d     = sample_q;
      theta_d      = theta_q;
      phi_d        = phi_q;
      sample_req_d = 1'b0;
      busy_d       = busy_q;
      done_d       = 1'b0;
      max_volt_d   = max_volt_q;
      max_theta_d  = max_theta_q;
      max_phi_d    = max_phi_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = SETTLE;
               cnt_d       = '0;
               first_d     = 1'b1;
               theta_d     = '0;
               phi_d       = '0;
               max_volt_d  = '0;
               max_theta_d = '0;
               max_phi_d   = '0;
               busy_d      = 1'b1;
            end
         end
         SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               state_d      = SAMPLE;
               sample_req_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SAMPLE: state_d = WAIT_ADC;
         WAIT_ADC: begin
            if (adc_valid) begin
               sample_d = adc_data;
               state_d  = EVAL;
            end
         end
         EVAL: begin
            max_volt_d  = new_volt;
            max_theta_d = new_theta;
            max_phi_d   = new_phi;
            first_d     = 1'b0;
            cnt_d       = '0;
            if (theta_q != THETA_LAST) begin
               theta_d = theta_q + ANG_W'(1);
               state_d = SETTLE;
            end else if (phi_q != PHI_LAST) begin
               theta_d = '0;
               phi_d   = phi_q + ANG_W'(1);
               state_d = SETTLE;
            end else begin
               theta_d = new_theta;
               phi_d   = new_phi;
               state_d = PARK;
            end
         end
         PARK: begin
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: state_d = IDLE;
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         first_q      <= 1'b0;
         sample_q     <= '0;
         theta_q      <= '0;
         phi_q        <= '0;
         sample_req_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         max_volt_q   <= '0;
         max_theta_q  <= '0;
         max_phi_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         first_q      <= first_d;
         sample_q     <= sample_d;
         theta_q      <= theta_d;
         phi_q        <= phi_d;
         sample_req_q <= sample_req_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         max_volt_q   <= max_volt_d;
         max_theta_q  <= max_theta_d;
         max_phi_q    <= max_phi_d;
      end
   end

   assign theta_idx  = theta_q;
   assign phi_idx    = phi_q;
   assign sample_req = sample_req_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign max_volt   = max_volt_q;
   assign max_theta  = max_theta_q;
   assign max_phi    = max_phi_q;

endmodule

// File: tb/tb_sweep_scan_controller.sv
// Scoreboard bench for sweep_scan_controller: stimulus pushes expected sample points and sweep results,
// an independent monitor pops and compares them as the DUT produces sample_req and done.
`timescale 1ns/1ps
module tb_sweep_scan_controller;

   localparam int TS = 4;
   localparam int PS = 2;
   localparam int SC = 2;
   localparam int NPTS = TS * PS;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        adc_valid = 1'b0;
   logic [11:0] adc_data = '0;
   logic [7:0]  theta_idx, phi_idx, max_theta, max_phi;
   logic        sample_req, busy, done;
   logic [11:0] max_volt;

   sweep_scan_controller #(
      .THETA_STEPS(TS), .PHI_STEPS(PS), .SETTLE_CYCLES(SC), .ADC_W(12), .ANG_W(8)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .adc_valid(adc_valid), .adc_data(adc_data),
      .theta_idx(theta_idx), .phi_idx(phi_idx), .sample_req(sample_req), .busy(busy), .done(done),
      .max_volt(max_volt), .max_theta(max_theta), .max_phi(max_phi)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int th; int ph; int cyc;} pt_t;
   typedef struct {int start_cyc; int done_cyc; int mv; int mt; int mp;} res_t;

   pt_t  exp_pts[$];
   res_t exp_res[$];
   logic [11:0] grid [0:PS-1][0:TS-1];
   bit   spurious_en = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ADC model: answers 3 cycles after sample_req with the grid value at the requested point.
   initial begin
      int th, ph;
      forever begin
         @(posedge clk); #1;
         if (sample_req) begin
            th = int'(theta_idx);
            ph = int'(phi_idx);
            repeat (3) begin @(posedge clk); #1; end
            adc_valid = 1'b1;
            adc_data  = (th < TS && ph < PS) ? grid[ph][th] : 12'h000;
            @(posedge clk); #1;
            adc_valid = 1'b0;
            adc_data  = '0;
            if (spurious_en) begin
               @(posedge clk); #1;
               adc_valid = 1'b1;
               adc_data  = 12'hFFF;
               @(posedge clk); #1;
               adc_valid = 1'b0;
               adc_data  = '0;
            end
         end
      end
   end

   // Monitor: all comparisons happen here, sampled on the falling edge.
   initial begin
      bit   rst_seen;
      int   samp_cnt;
      pt_t  p;
      res_t r;
      rst_seen = 1'b0;
      samp_cnt = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            rst_seen = 1'b1;
            exp_pts.delete();
            exp_res.delete();
            samp_cnt = 0;
         end else begin
            if (rst_seen) begin
               check("rst_theta", theta_idx, 0);
               check("rst_phi", phi_idx, 0);
               check("rst_sample_req", sample_req, 0);
               check("rst_busy", busy, 0);
               check("rst_done", done, 0);
               check("rst_max_volt", max_volt, 0);
               check("rst_max_theta", max_theta, 0);
               check("rst_max_phi", max_phi, 0);
               rst_seen = 1'b0;
            end
            if (exp_res.size() > 0 && cyc == exp_res[0].start_cyc + 1)
               check("busy_rise", busy, 1);
            if (exp_res.size() > 0 && cyc == exp_res[0].done_cyc - 1)
               check("busy_park", busy, 1);
            if (sample_req) begin
               samp_cnt++;
               if (exp_pts.size() == 0) begin
                  check("unexpected_sample_req", 1, 0);
               end else begin
                  p = exp_pts.pop_front();
                  check("sample_theta", theta_idx, p.th);
                  check("sample_phi", phi_idx, p.ph);
                  check("sample_cycle", cyc, p.cyc);
               end
            end
            if (done) begin
               if (exp_res.size() == 0) begin
                  check("unexpected_done", 1, 0);
               end else begin
                  r = exp_res.pop_front();
                  check("done_cycle", cyc, r.done_cyc);
                  check("max_volt", max_volt, r.mv);
                  check("max_theta", max_theta, r.mt);
                  check("max_phi", max_phi, r.mp);
                  check("park_theta", theta_idx, r.mt);
                  check("park_phi", phi_idx, r.mp);
                  check("busy_at_done", busy, 0);
                  check("sample_count", samp_cnt, NPTS);
               end
               samp_cnt = 0;
            end else if (exp_res.size() > 0 && cyc > exp_res[0].done_cyc + 20) begin
               check("done_timeout", 0, 1);
               void'(exp_res.pop_front());
               exp_pts.delete();
               samp_cnt = 0;
            end
         end
      end
   end

   // Reference: peak is the largest value; its location is the first raster point holding it.
   task automatic launch();
      res_t r;
      pt_t  p;
      int   best;
      int   idx;
      best = 0;
      for (int ph = 0; ph < PS; ph++)
         for (int th = 0; th < TS; th++)
            if (int'(grid[ph][th]) > best) best = int'(grid[ph][th]);
      idx = -1;
      for (int i = 0; i < NPTS && idx < 0; i++)
         if (int'(grid[i / TS][i % TS]) == best) idx = i;
      start = 1'b1;
      r.start_cyc = cyc;
      r.mv = best;
      r.mt = idx % TS;
      r.mp = idx / TS;
      // Per point: SETTLE (SC+1) + SAMPLE 1 + ADC wait 3 + EVAL 1; then PARK (SC+1) and DONE.
      for (int i = 0; i < NPTS; i++) begin
         p.th  = i % TS;
         p.ph  = i / TS;
         p.cyc = cyc + (SC + 2) + i * (SC + 6);
         exp_pts.push_back(p);
      end
      r.done_cyc = cyc + NPTS * (SC + 6) + (SC + 1) + 1;
      exp_res.push_back(r);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400; i++) begin
         if (done) break;
         @(posedge clk); #1;
      end
   endtask

   task automatic fill_const(input logic [11:0] v);
      for (int ph = 0; ph < PS; ph++)
         for (int th = 0; th < TS; th++)
            grid[ph][th] = v;
   endtask

   task automatic fill_rand(input int hi);
      for (int ph = 0; ph < PS; ph++)
         for (int th = 0; th < TS; th++)
            grid[ph][th] = 12'($urandom_range(0, hi));
   endtask

   initial begin
      int n;
      fill_const(12'h000);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) begin @(posedge clk); #1; end

      // Single peak
      fill_const(12'h100);
      grid[1][2] = 12'h7A0;
      launch();
      wait_done();
      repeat (2) begin @(posedge clk); #1; end

      // All-zero grid: first point wins
      fill_const(12'h000);
      launch();
      wait_done();
      repeat (2) begin @(posedge clk); #1; end

      // Tie: earliest of two equal peaks
      fill_const(12'h000);
      grid[0][1] = 12'h500;
      grid[1][3] = 12'h500;
      launch();
      wait_done();
      repeat (2) begin @(posedge clk); #1; end

      // Start while busy plus spurious adc_valid during settle
      fill_rand(12'h7FF);
      spurious_en = 1'b1;
      launch();
      n = 0;
      for (int i = 0; i < 400 && n < 5; i++) begin
         if (sample_req) n++;
         if (n < 5) begin @(posedge clk); #1; end
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();
      spurious_en = 1'b0;
      repeat (6) begin @(posedge clk); #1; end

      // Back-to-back sweeps: start in the cycle after done
      fill_rand(12'hFFF);
      launch();
      wait_done();
      @(posedge clk); #1;
      fill_rand(12'h0FF);
      launch();
      wait_done();
      repeat (2) begin @(posedge clk); #1; end

      // Reset while waiting on the ADC; late adc_valid must be ignored
      fill_rand(12'hFFF);
      launch();
      n = 0;
      for (int i = 0; i < 400 && n < 2; i++) begin
         if (sample_req) n++;
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (30) begin @(posedge clk); #1; end

      // Random sweeps with coarse values to provoke ties
      for (int k = 0; k < 4; k++) begin
         for (int ph = 0; ph < PS; ph++)
            for (int th = 0; th < TS; th++)
               grid[ph][th] = 12'($urandom_range(0, 3) << 8);
         launch();
         wait_done();
         repeat (1 + $urandom_range(0, 3)) begin @(posedge clk); #1; end
      end

      repeat (30) begin @(posedge clk); #1; end
      if (exp_res.size() != 0 || exp_pts.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL pending_expectations: got %0d results/%0d points outstanding, expected 0",
                  exp_res.size(), exp_pts.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
